// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants, coordinate width and sync polarity
// encodings for the VGA raster timing generator.
package vga_timing_pkg;

  localparam int unsigned H_VISIBLE_640 = 640;
  localparam int unsigned H_FRONT_640   = 16;
  localparam int unsigned H_SYNC_640    = 96;
  localparam int unsigned H_BACK_640    = 48;

  localparam int unsigned V_VISIBLE_480 = 480;
  localparam int unsigned V_FRONT_480   = 10;
  localparam int unsigned V_SYNC_480    = 2;
  localparam int unsigned V_BACK_480    = 33;

  localparam int unsigned H_TOTAL_640 = H_VISIBLE_640 + H_FRONT_640 + H_SYNC_640 + H_BACK_640;
  localparam int unsigned V_TOTAL_480 = V_VISIBLE_480 + V_FRONT_480 + V_SYNC_480 + V_BACK_480;

  localparam int unsigned COORD_W     = 10;
  localparam int unsigned COORD_LIMIT = 1 << COORD_W;

  typedef enum logic {
    SYNC_ACTIVE_LOW  = 1'b0,
    SYNC_ACTIVE_HIGH = 1'b1
  } sync_pol_e;

endpackage

// File: rtl/pixel_tick_gen.sv
// Clock divider: produces a one-cycle pixel strobe every CLK_DIV system
// clocks; the strobe is suppressed while reset is asserted.
module pixel_tick_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;

  always_comb begin
    div_d = div_q + 1'b1;
    if (div_q == DIV_LAST) div_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) div_q <= '0;
    else       div_q <= div_d;
  end

  assign tick_o = (div_q == DIV_LAST) && !rst_i;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel counters, sync decode, colour blanking and a
// per-frame strobe. Define VGA_RGB_REG_EN to register colour and sync pins.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_VISIBLE = H_VISIBLE_640,
  parameter int unsigned H_FRONT   = H_FRONT_640,
  parameter int unsigned H_SYNC    = H_SYNC_640,
  parameter int unsigned H_BACK    = H_BACK_640,
  parameter int unsigned V_VISIBLE = V_VISIBLE_480,
  parameter int unsigned V_FRONT   = V_FRONT_480,
  parameter int unsigned V_SYNC    = V_SYNC_480,
  parameter int unsigned V_BACK    = V_BACK_480,
  parameter int unsigned CLK_DIV   = 4,
  parameter logic        SYNC_POL  = SYNC_ACTIVE_LOW
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               R_in,
  input  logic               G_in,
  input  logic               B_in,
  output logic [COORD_W-1:0] CounterX,
  output logic [COORD_W-1:0] CounterY,
  output logic               inDisplayArea,
  output logic               PixelTick,
  output logic               FrameTick,
  output logic               vga_h_sync,
  output logic               vga_v_sync,
  output logic               vga_r,
  output logic               vga_g,
  output logic               vga_b
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  if (H_TOTAL > COORD_LIMIT) begin : g_h_total_chk
    $error("vga_timing_gen: H_TOTAL exceeds coordinate range");
  end
  if (V_TOTAL > COORD_LIMIT) begin : g_v_total_chk
    $error("vga_timing_gen: V_TOTAL exceeds coordinate range");
  end
  if (CLK_DIV < 1) begin : g_clk_div_chk
    $error("vga_timing_gen: CLK_DIV must be at least 1");
  end

  localparam logic [COORD_W-1:0] X_LAST   = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] Y_LAST   = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] X_VIS    = COORD_W'(H_VISIBLE);
  localparam logic [COORD_W-1:0] Y_VIS    = COORD_W'(V_VISIBLE);
  localparam logic [COORD_W-1:0] Y_VIS_LAST = COORD_W'(V_VISIBLE - 1);
  localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_VISIBLE + H_FRONT);
  localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_VISIBLE + V_FRONT);
  localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_VISIBLE + V_FRONT + V_SYNC);

  logic               pix_tick;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic               frame_q, frame_d;
  logic               disp, hs_act, vs_act;
  logic               hs_c, vs_c, r_c, g_c, b_c;

  pixel_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_pixel_tick_gen (
    .clk_i  (Clk),
    .rst_i  (Reset),
    .tick_o (pix_tick)
  );

  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    frame_d = pix_tick && (x_q == X_LAST) && (y_q == Y_VIS_LAST);
    if (pix_tick) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      x_q     <= '0;
      y_q     <= '0;
      frame_q <= 1'b0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      frame_q <= frame_d;
    end
  end

  assign disp   = (x_q < X_VIS) && (y_q < Y_VIS);
  assign hs_act = (x_q >= HS_START) && (x_q < HS_END);
  assign vs_act = (y_q >= VS_START) && (y_q < VS_END);

  // Reset is synchronous for the state, but the pins must already be quiet
  // during the reset cycle itself, so it also gates the pin decode.
  assign hs_c = (hs_act && !Reset) ? SYNC_POL : ~SYNC_POL;
  assign vs_c = (vs_act && !Reset) ? SYNC_POL : ~SYNC_POL;
  assign r_c  = R_in && disp && !Reset;
  assign g_c  = G_in && disp && !Reset;
  assign b_c  = B_in && disp && !Reset;

`ifdef VGA_RGB_REG_EN
  logic hs_q, vs_q, r_q, g_q, b_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      hs_q <= ~SYNC_POL;
      vs_q <= ~SYNC_POL;
      r_q  <= 1'b0;
      g_q  <= 1'b0;
      b_q  <= 1'b0;
    end else begin
      hs_q <= hs_c;
      vs_q <= vs_c;
      r_q  <= r_c;
      g_q  <= g_c;
      b_q  <= b_c;
    end
  end

  assign vga_h_sync = hs_q;
  assign vga_v_sync = vs_q;
  assign vga_r      = r_q;
  assign vga_g      = g_q;
  assign vga_b      = b_q;
`else
  assign vga_h_sync = hs_c;
  assign vga_v_sync = vs_c;
  assign vga_r      = r_c;
  assign vga_g      = g_c;
  assign vga_b      = b_c;
`endif

  assign CounterX      = x_q;
  assign CounterY      = y_q;
  assign inDisplayArea = disp;
  assign PixelTick     = pix_tick;
  assign FrameTick     = frame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen using a reduced raster so many frames
// fit in a short run; expected outputs come from elapsed-cycle arithmetic.
module tb_vga_timing_gen;

  localparam int HV = 8, HF = 2, HS = 3, HB = 2;
  localparam int VV = 6, VF = 1, VS = 2, VB = 1;
  localparam int DIV = 4;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int NCYC = 8000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       r_in = 1'b0, g_in = 1'b0, b_in = 1'b0;
  logic [9:0] cx, cy;
  logic       disp, ptick, ftick, hsync, vsync, vr, vg, vb;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_VISIBLE (HV), .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
    .V_VISIBLE (VV), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB),
    .CLK_DIV   (DIV), .SYNC_POL (1'b0)
  ) dut (
    .Clk (clk), .Reset (rst), .R_in (r_in), .G_in (g_in), .B_in (b_in),
    .CounterX (cx), .CounterY (cy), .inDisplayArea (disp),
    .PixelTick (ptick), .FrameTick (ftick),
    .vga_h_sync (hsync), .vga_v_sync (vsync),
    .vga_r (vr), .vga_g (vg), .vga_b (vb)
  );

  typedef struct {
    int x, y;
    bit disp, pt, ft, hs, vs, r, g, b;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   ft_model = 0;
  int   ft_seen = 0;

  // t counts system clocks since the last sampled reset; the raster position
  // is simply the number of whole pixel periods elapsed, modulo one frame.
  function automatic exp_t model(int t, bit rs, bit ri, bit gi, bit bi);
    exp_t e;
    int pix;
    pix    = (t / DIV) % FRAME;
    e.x    = pix % HT;
    e.y    = pix / HT;
    e.disp = (e.x < HV) && (e.y < VV);
    e.pt   = ((t % DIV) == DIV - 1) && !rs;
    e.ft   = (t > 0) && ((t % DIV) == 0) && (pix == HT * VV);
    e.hs   = (!rs && e.x >= HV + HF && e.x < HV + HF + HS) ? 1'b0 : 1'b1;
    e.vs   = (!rs && e.y >= VV + VF && e.y < VV + VF + VS) ? 1'b0 : 1'b1;
    e.r    = ri && e.disp && !rs;
    e.g    = gi && e.disp && !rs;
    e.b    = bi && e.disp && !rs;
    return e;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: the DUT presents a full set of outputs every cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      if (ftick === 1'b1) ft_seen++;
      chk("CounterX",      {22'b0, cx}, e.x);
      chk("CounterY",      {22'b0, cy}, e.y);
      chk("inDisplayArea", {31'b0, disp}, {31'b0, e.disp});
      chk("PixelTick",     {31'b0, ptick}, {31'b0, e.pt});
      chk("FrameTick",     {31'b0, ftick}, {31'b0, e.ft});
      chk("vga_h_sync",    {31'b0, hsync}, {31'b0, e.hs});
      chk("vga_v_sync",    {31'b0, vsync}, {31'b0, e.vs});
      chk("vga_r",         {31'b0, vr}, {31'b0, e.r});
      chk("vga_g",         {31'b0, vg}, {31'b0, e.g});
      chk("vga_b",         {31'b0, vb}, {31'b0, e.b});
    end
  end

  // Stimulus: random colour every cycle, 3-cycle power-on reset, one forced
  // mid-frame reset and sparse random reset pulses.
  initial begin
    exp_t cur, prev, pushed;
    int   t;
    bit   valid;
    t     = 0;
    valid = 1'b0;
    prev  = model(0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      #1;
      if (rst) begin
        t     = 0;
        valid = 1'b1;
      end else begin
        t++;
      end
      rst  = (cyc < 2) || (cyc == 1001) || (cyc > 2 && $urandom_range(0, 599) == 0);
      r_in = 1'($urandom);
      g_in = 1'($urandom);
      b_in = 1'($urandom);
      cur    = model(t, rst, r_in, g_in, b_in);
      pushed = cur;
`ifdef VGA_RGB_REG_EN
      pushed.hs = prev.hs;
      pushed.vs = prev.vs;
      pushed.r  = prev.r;
      pushed.g  = prev.g;
      pushed.b  = prev.b;
`endif
      prev = cur;
      if (valid) begin
        q.push_back(pushed);
        if (cur.ft) ft_model++;
      end
    end
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);
    chk("frame_tick_count", ft_seen, ft_model);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Generates 640x480@60 VGA raster timing from the system clock.
- Produces the pixel coordinates CounterX/CounterY and the inDisplayArea flag that the drawing logic consumes.
- Gates the drawing logic's R/G/B to the VGA pins and drives hsync/vsync.
- Emits a once-per-frame strobe so game state (aliens, player, bullet) updates only during vertical blanking.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- CLK_DIV, 4, Clk cycles per pixel (100 MHz -> 25 MHz); must be >= 1
- SYNC_POL, 0, sync active level (0 = active-low)

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- R_in  in  1  red from the drawing logic for the current CounterX/CounterY
- G_in  in  1  green from the drawing logic
- B_in  in  1  blue from the drawing logic
- CounterX  out  10  current pixel column, 0..H_TOTAL-1
- CounterY  out  10  current line, 0..V_TOTAL-1
- inDisplayArea  out  1  CounterX<H_VISIBLE && CounterY<V_VISIBLE
- PixelTick  out  1  one-Clk pulse; counters advance on this cycle
- FrameTick  out  1  one-Clk pulse at the start of vertical blanking
- vga_h_sync  out  1  horizontal sync
- vga_v_sync  out  1  vertical sync
- vga_r  out  1  red to pin
- vga_g  out  1  green to pin
- vga_b  out  1  blue to pin

Behaviour:
- Derived values: H_TOTAL = sum of H_*, 800. V_TOTAL = sum of V_*, 525. Elaboration fails if H_TOTAL>1024 or V_TOTAL>1024.
- Divider: counter div runs 0..CLK_DIV-1 and wraps. PixelTick = (div==CLK_DIV-1) && !Reset. With CLK_DIV=1, PixelTick is high every non-reset cycle.
- Counter advance, on a Clk edge with PixelTick=1:
  - CounterX==H_TOTAL-1: CounterX<=0, and CounterY<=(CounterY==V_TOTAL-1)?0:CounterY+1.
  - Otherwise: CounterX<=CounterX+1; CounterY holds.
- Counters hold between ticks. Wrap compares are exact equality. Widths are 10-bit unsigned with no overflow (guaranteed by the elaboration check).
- Sync decode, combinational from the counter registers:
  - hsync active when H_VISIBLE+H_FRONT <= CounterX < H_VISIBLE+H_FRONT+H_SYNC, i.e. 656..751.
  - vsync active when V_VISIBLE+V_FRONT <= CounterY < V_VISIBLE+V_FRONT+V_SYNC, i.e. 490..491.
  - Active level = SYNC_POL; inactive = ~SYNC_POL.
- inDisplayArea: combinational from the counter registers, same cycle as the counters.
- FrameTick: registered. FrameTick <= PixelTick && CounterX==H_TOTAL-1 && CounterY==V_VISIBLE-1. It is therefore high exactly for the first Clk cycle in which the counters read (0,V_VISIBLE). Exactly one pulse per frame.
- Colour: vga_c = c_in & inDisplayArea. Blanking always forces 0.
- Reset (synchronous, wins over everything):
  - div, CounterX, CounterY = 0; FrameTick = 0; PixelTick = 0.
  - Syncs at the inactive level; vga_r/g/b = 0.
- Reset mid-frame: counters read (0,0) on the cycle after Reset is sampled. The first PixelTick after Reset deasserts occurs CLK_DIV cycles later. No FrameTick is produced for the aborted frame.

Optional Feature:
Macro VGA_RGB_REG_EN.
- Defined:
  - vga_r/g/b <= c_in & inDisplayArea on every Clk.
  - vga_h_sync/vga_v_sync are also registered, so colour and sync stay aligned (one Clk latency from counters to pins).
  - Reset drives the registered colours to 0 and the registered syncs inactive.
  - FrameTick, PixelTick and the counters are unchanged.
- Undefined: colour and sync outputs are combinational, zero latency.

Decomposition:
- Package vga_timing_pkg holds:
  - 640x480 timing constants.
  - H_TOTAL/V_TOTAL.
  - Coordinate width localparam (10).
  - Sync-polarity constants.
- One natural sub-module: pixel_tick_gen, which contains the CLK_DIV divider and produces PixelTick. Counters, decode and output gating live in the top.

Test Plan:
- Reset for 3 cycles: CounterX=0, CounterY=0, syncs=1, vga_r/g/b=0, FrameTick=0. The first PixelTick appears on the 4th cycle after release.
- Free-run with CLK_DIV=4: PixelTick exactly every 4th Clk. At (799,Y) the next tick gives (0,Y+1). At (799,524) the next tick gives (0,0).
- Line scan: vga_h_sync low for CounterX 656..751 only (96 pixels = 384 Clk). vsync low for CounterY 490..491 only (2 lines = 1600 pixels).
- FrameTick: exactly one pulse per 1,680,000 Clk (800*525*4). It coincides with the first cycle of (0,480). No pulse on any other cycle.
- Gating with R_in=G_in=B_in=1:
  - vga_r=1 at X=639,Y=10; vga_r=0 at X=640; vga_r=0 at Y=480.
  - With VGA_RGB_REG_EN, same values one Clk later, with syncs also delayed one Clk.
- Reset asserted at (300,200) for one cycle: next cycle shows (0,0), no FrameTick, syncs inactive. Counting resumes normally.
